regbank_wb_arbiter: RTL and testbench
=====================================

# regbank_wb_arbiter

Write-port arbiter and pending-write scoreboard for the CPU register bank. Two writeback requesters share the bank's single write port: requester 0 is the ALU and requester 1 is the load/store unit. Each requester has a one-entry holding slot. One accepted write is issued per cycle through a registered output stage. A per-register pending bitmask tells decode which destinations still have writes in flight.

## Interface
Parameters:
- NUMREGS, 32, number of architectural registers; register 0 is hard-wired zero.
- DATAWIDTH, 32, write data width.
- CNTWIDTH, 16, stall counter width.

Ports (AW = $clog2(NUMREGS)):
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_0_i  in  1  ALU write request.
- ready_0_o  out  1  ALU slot can accept.
- addr_0_i  in  AW  ALU destination register.
- data_0_i  in  DATAWIDTH  ALU write data.
- valid_1_i, ready_1_o, addr_1_i, data_1_i: same as the four ALU ports, for the LSU.
- alloc_i  in  1  decode marks a destination pending.
- alloc_addr_i  in  AW  register being allocated.
- we_o  out  1  to bank write enable.
- waddr_o  out  AW  to bank write address.
- wdata_o  out  DATAWIDTH  to bank write data.
- pend_o  out  NUMREGS  pending-write bitmask.
- stall_cnt_o  out  CNTWIDTH  saturating count of stalled request cycles.

## Operation
- **Handshake.** A transfer on requester k occurs at a rising edge where valid_k_i && ready_k_o. The accepted addr/data are loaded into slot k. Inputs are sampled only on transfer.
- **Ready.** ready_k_o = !full_k || grant_k. It depends on state only, with no input-to-output combinational path.
- **Grant.** Grant is computed from slot state only.
  - Exactly one full slot: that slot is granted.
  - Both slots full: the round-robin pointer decides (see Configuration).
  - No full slot: no grant.
- **Issue.** On a granted edge, the output stage loads the granted slot's addr/data and sets we_o = (addr != 0). The slot is freed, and a same-edge transfer may refill it. With no grant, we_o loads 0 and waddr_o/wdata_o hold their values.
- **Register 0.** A write to register 0 is accepted and consumes its grant cycle, but it never asserts we_o.
- **Scoreboard set.** At an edge with alloc_i && alloc_addr_i != 0, bit alloc_addr_i of pend_o is set.
- **Scoreboard clear.** At an edge with we_o == 1, bit waddr_o is cleared.
- **Scoreboard collision.** If a set and a clear target the same bit at the same edge, set wins.
- **Scoreboard bit 0.** pend_o[0] is always 0.
- **Stall counter.** stall_cnt_o increments at each edge where valid_k_i && !ready_k_o, counting per requester, so it can step by 2 in one cycle. It saturates at all-ones and never wraps.

## Timing
- **Reset values:**
  - ready_0_o = ready_1_o = 1 (both slots empty).
  - we_o = 0, waddr_o = 0, wdata_o = 0.
  - pend_o = 0.
  - stall_cnt_o = 0.
  - Round-robin pointer last = 1, so the first tie goes to requester 0.
- **Reset mid-operation:** buffered slot contents are discarded and not written to the bank; pend_o clears.
- **Latency with an empty slot and no contention:**
  - Edge N: transfer into the slot.
  - Edge N+1: grant; we_o is high during cycle N+1..N+2.
  - Edge N+2: bank commits.
- **Throughput:** one issue per cycle total. A single requester can sustain one write per cycle, since ready stays high while its slot is granted every cycle.
- **Bank write-bypass:** during the cycle we_o is high, bank reads of waddr_o already return wdata_o, but pend_o for that register is still 1 until the next edge.

## Configuration
- **WB_RR_EN defined:** on a tie, grant goes to !last, and last updates to the granted index on every grant. Neither requester waits more than one issue cycle behind the other.
- **WB_RR_EN undefined:** fixed priority. On a tie, requester 1 (LSU) always wins, and the last pointer is not implemented. Requester 0 may starve while requester 1 streams.

## Test plan
- **Reset values:** assert rst_i mid-stream with both slots full. Required: ready_0_o = ready_1_o = 1, we_o = 0, pend_o = 0, stall_cnt_o = 0, and no bank write of the buffered data.
- **Single ALU write:** ALU writes addr 5, data 0xDEADBEEF, with 0 at edge N. Required: we_o = 1, waddr_o = 5, wdata_o = 0xDEADBEEF in cycle N+1..N+2 only.
- **Simultaneous requests:** ALU (3, 0x11) and LSU (4, 0x22) hold valid for 3 cycles with new data each cycle.
  - With WB_RR_EN: issue order alternates 3, 4, 3, 4…
  - Without WB_RR_EN: LSU is issued every cycle, ready_0_o stays 0, and stall_cnt_o increments by 1 per cycle.
- **Register 0 write:** ALU writes addr 0, data 0xFFFFFFFF. Required: the handshake completes, we_o stays 0, and pend_o is unchanged.
- **Scoreboard:** alloc addr 7 → pend_o[7] = 1. Next, alloc 7 again in the same cycle that we_o writes 7 → pend_o[7] stays 1. A later write to 7 with no alloc → pend_o[7] = 0.
- **Saturation:** with CNTWIDTH = 4, hold valid_1_i high while ready_1_o = 0 for 20 cycles. Required: stall_cnt_o reaches 15 and holds there.

Source files
------------

// File: rtl/regbank_wb_arbiter.sv
// Write-port arbiter for the register bank: two one-entry writeback slots (ALU, LSU),
// a registered bank write stage, a pending-write scoreboard and a saturating stall counter.
// Define WB_RR_EN for round-robin tie-breaking; otherwise the LSU wins every tie.
module regbank_wb_arbiter #(
  parameter int NUMREGS   = 32,
  parameter int DATAWIDTH = 32,
  parameter int CNTWIDTH  = 16,
  localparam int AW       = $clog2(NUMREGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_0_i,
  output logic                 ready_0_o,
  input  logic [AW-1:0]        addr_0_i,
  input  logic [DATAWIDTH-1:0] data_0_i,
  input  logic                 valid_1_i,
  output logic                 ready_1_o,
  input  logic [AW-1:0]        addr_1_i,
  input  logic [DATAWIDTH-1:0] data_1_i,
  input  logic                 alloc_i,
  input  logic [AW-1:0]        alloc_addr_i,
  output logic                 we_o,
  output logic [AW-1:0]        waddr_o,
  output logic [DATAWIDTH-1:0] wdata_o,
  output logic [NUMREGS-1:0]   pend_o,
  output logic [CNTWIDTH-1:0]  stall_cnt_o
);

  logic                 full_0, full_1;
  logic [AW-1:0]        slot_addr_0, slot_addr_1;
  logic [DATAWIDTH-1:0] slot_data_0, slot_data_1;
  logic                 grant_0, grant_1;
  logic                 xfer_0, xfer_1;
  logic [AW-1:0]        issue_addr;
  logic [DATAWIDTH-1:0] issue_data;
  logic [NUMREGS-1:0]   pend_q, pend_set, pend_clr, pend_next;
  logic [CNTWIDTH-1:0]  stall_cnt_q;
  logic [1:0]           stall_inc;
  logic [CNTWIDTH:0]    stall_sum;

`ifdef WB_RR_EN
  logic last;
`endif

  // Grant looks at slot occupancy only, so ready has no path from any input.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (full_0 && full_1) begin
`ifdef WB_RR_EN
      grant_0 = last;
      grant_1 = !last;
`else
      grant_1 = 1'b1;
`endif
    end else begin
      grant_0 = full_0;
      grant_1 = full_1;
    end
  end

  assign ready_0_o = !full_0 || grant_0;
  assign ready_1_o = !full_1 || grant_1;
  assign xfer_0    = valid_0_i && ready_0_o;
  assign xfer_1    = valid_1_i && ready_1_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst_i) begin
      full_0 <= 1'b0;
      full_1 <= 1'b0;
    end else begin
      if (xfer_0)       full_0 <= 1'b1;
      else if (grant_0) full_0 <= 1'b0;
      if (xfer_1)       full_1 <= 1'b1;
      else if (grant_1) full_1 <= 1'b0;
    end
  end

  // NOTE: slot payloads carry no reset; the full bits qualify them, so stale contents are never issued.
  always_ff @(posedge clk_i) begin
    if (xfer_0) begin
      slot_addr_0 <= addr_0_i;
      slot_data_0 <= data_0_i;
    end
    if (xfer_1) begin
      slot_addr_1 <= addr_1_i;
      slot_data_1 <= data_1_i;
    end
  end

`ifdef WB_RR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        last <= 1'b1;
    else if (grant_0) last <= 1'b0;
    else if (grant_1) last <= 1'b1;
  end
`endif

  assign issue_addr = grant_1 ? slot_addr_1 : slot_addr_0;
  assign issue_data = grant_1 ? slot_data_1 : slot_data_0;

  // A register-0 write still burns its issue cycle but never reaches the bank.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (grant_0 || grant_1) begin
      we_o    <= (issue_addr != '0);
      waddr_o <= issue_addr;
      wdata_o <= issue_data;
    end else begin
      we_o    <= 1'b0;
    end
  end

  // Set is applied after clear so a same-edge alloc of a retiring register keeps it pending.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (alloc_i && (alloc_addr_i != '0)) pend_set[alloc_addr_i] = 1'b1;
    if (we_o)                            pend_clr[waddr_o]      = 1'b1;
    pend_next    = (pend_q & ~pend_clr) | pend_set;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= pend_next;
  end

  assign pend_o = pend_q;

  assign stall_inc = {1'b0, (valid_0_i && !ready_0_o)} + {1'b0, (valid_1_i && !ready_1_o)};
  assign stall_sum = {1'b0, stall_cnt_q} + {{(CNTWIDTH-1){1'b0}}, stall_inc};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                stall_cnt_q <= '0;
    else if (stall_sum[CNTWIDTH]) stall_cnt_q <= '1;
    else                      stall_cnt_q <= stall_sum[CNTWIDTH-1:0];
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Randomized scoreboard bench for regbank_wb_arbiter: a queue-based reference model predicts
// bank writes, ready, pending mask and stall count; a negedge monitor compares.
module tb_regbank_wb_arbiter;
  localparam int NUMREGS = 32;
  localparam int DW      = 32;
  localparam int CW      = 4;
  localparam int AW      = 5;
  localparam int SATMAX  = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_0_i, valid_1_i, alloc_i;
  logic          ready_0_o, ready_1_o, we_o;
  logic [AW-1:0] addr_0_i, addr_1_i, alloc_addr_i, waddr_o;
  logic [DW-1:0] data_0_i, data_1_i, wdata_o;
  logic [NUMREGS-1:0] pend_o;
  logic [CW-1:0] stall_cnt_o;

  regbank_wb_arbiter #(.NUMREGS(NUMREGS), .DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid_0_i(valid_0_i), .ready_0_o(ready_0_o), .addr_0_i(addr_0_i), .data_0_i(data_0_i),
    .valid_1_i(valid_1_i), .ready_1_o(ready_1_o), .addr_1_i(addr_1_i), .data_1_i(data_1_i),
    .alloc_i(alloc_i), .alloc_addr_i(alloc_addr_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .pend_o(pend_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t slot0_q[$];
  wr_t slot1_q[$];
  wr_t exp_q[$];
  int  issued[$];
  bit  m_pend[NUMREGS];
  int  m_stall;
  bit  m_last;
  bit  m_we;
  int  m_waddr;
  bit  m_rdy0, m_rdy1;
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which requester wins given which slots hold a write; the tie rule is the configurable part.
  function automatic void pick(output bit g0, output bit g1);
    bit f0, f1, tie0;
    f0 = slot0_q.size() != 0;
    f1 = slot1_q.size() != 0;
`ifdef WB_RR_EN
    tie0 = m_last;
`else
    tie0 = 1'b0;
`endif
    g0 = f0 && (!f1 || tie0);
    g1 = f1 && !g0;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    bit g0, g1;
    wr_t w;
    if (rst_i) begin
      slot0_q.delete();
      slot1_q.delete();
      exp_q.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_stall = 0;
      m_last  = 1'b1;
      m_we    = 1'b0;
      m_waddr = 0;
      m_rdy0  = 1'b1;
      m_rdy1  = 1'b1;
    end else begin
      pick(g0, g1);
      m_stall += int'(valid_0_i && !m_rdy0) + int'(valid_1_i && !m_rdy1);
      if (m_stall > SATMAX) m_stall = SATMAX;
      if (m_we) m_pend[m_waddr] = 1'b0;
      if (alloc_i && alloc_addr_i != 0) m_pend[alloc_addr_i] = 1'b1;
      m_we = 1'b0;
      if (g0 || g1) begin
        w = g0 ? slot0_q.pop_front() : slot1_q.pop_front();
        m_waddr = int'(w.addr);
        m_we    = (w.addr != 0);
        if (m_we) exp_q.push_back(w);
        m_last = g1;
      end
      if (valid_0_i && m_rdy0) slot0_q.push_back('{addr_0_i, data_0_i});
      if (valid_1_i && m_rdy1) slot1_q.push_back('{addr_1_i, data_1_i});
      pick(g0, g1);
      m_rdy0 = (slot0_q.size() == 0) || g0;
      m_rdy1 = (slot1_q.size() == 0) || g1;
    end
  end

  always @(negedge clk_i) begin
    logic [NUMREGS-1:0] exp_pend;
    wr_t w;
    foreach (m_pend[i]) exp_pend[i] = m_pend[i];
    check("ready_0", ready_0_o, m_rdy0);
    check("ready_1", ready_1_o, m_rdy1);
    check("we", we_o, m_we);
    check("pend", pend_o, exp_pend);
    check("stall_cnt", stall_cnt_o, m_stall);
    if (we_o === 1'b1) begin
      issued.push_back(int'(waddr_o));
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL bank_write: got write addr %0d data 0x%0h, expected none", waddr_o, wdata_o);
      end else begin
        w = exp_q.pop_front();
        check("waddr", waddr_o, w.addr);
        check("wdata", wdata_o, w.data);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    valid_0_i = 1'b0;
    valid_1_i = 1'b0;
    alloc_i   = 1'b0;
  endtask

  task automatic alu_write(input int a, input logic [DW-1:0] d);
    valid_0_i = 1'b1;
    addr_0_i  = AW'(a);
    data_0_i  = d;
    step();
    valid_0_i = 1'b0;
  endtask

  initial begin
    int exp_order[4];
    idle();
    addr_0_i = '0; addr_1_i = '0; data_0_i = '0; data_1_i = '0; alloc_addr_i = '0;
    repeat (2) step();
    rst_i = 1'b0;
    step();
    check("rst_ready_0", ready_0_o, 1);
    check("rst_ready_1", ready_1_o, 1);
    check("rst_we", we_o, 0);
    check("rst_waddr", waddr_o, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_pend", pend_o, 0);
    check("rst_stall", stall_cnt_o, 0);

    // Single ALU write: visible on the bank port exactly one cycle after the transfer.
    alu_write(5, 32'hDEADBEEF);
    check("single_we_n", we_o, 0);
    step();
    check("single_we_n1", we_o, 1);
    check("single_waddr", waddr_o, 5);
    check("single_wdata", wdata_o, 32'hDEADBEEF);
    step();
    check("single_we_n2", we_o, 0);

    // Both requesters stream for three cycles.
    issued.delete();
    for (int i = 0; i < 3; i++) begin
      valid_0_i = 1'b1; addr_0_i = 3; data_0_i = 32'h11 + i;
      valid_1_i = 1'b1; addr_1_i = 4; data_1_i = 32'h22 + i;
      step();
    end
    idle();
    repeat (6) step();
`ifdef WB_RR_EN
    exp_order = '{3, 4, 3, 4};
`else
    exp_order = '{4, 4, 4, 3};
`endif
    check("contend_count", issued.size(), 4);
    for (int i = 0; i < 4 && i < issued.size(); i++)
      check($sformatf("contend_order[%0d]", i), issued[i], exp_order[i]);

    // Register 0: handshake completes, nothing reaches the bank.
    valid_0_i = 1'b1; addr_0_i = 0; data_0_i = 32'hFFFFFFFF;
    check("r0_ready", ready_0_o, 1);
    step();
    valid_0_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("r0_we", we_o, 0);
      step();
    end

    // Scoreboard set / collision / clear on register 7.
    alloc_i = 1'b1; alloc_addr_i = 7;
    step();
    alloc_i = 1'b0;
    check("sb_set", pend_o[7], 1);
    alu_write(7, 32'h7777);
    step();
    check("sb_collide_we", we_o, 1);
    check("sb_collide_waddr", waddr_o, 7);
    alloc_i = 1'b1; alloc_addr_i = 7;
    step();
    alloc_i = 1'b0;
    check("sb_collide_keep", pend_o[7], 1);
    alu_write(7, 32'h7778);
    repeat (2) step();
    check("sb_clear", pend_o[7], 0);

    // Stall counter saturation, starting from a clean reset.
    rst_i = 1'b1; step(); rst_i = 1'b0; step();
    for (int i = 0; i < 20; i++) begin
      valid_0_i = 1'b1; addr_0_i = AW'($urandom); data_0_i = $urandom;
      valid_1_i = 1'b1; addr_1_i = AW'($urandom); data_1_i = $urandom;
      step();
    end
    check("sat_cnt", stall_cnt_o, SATMAX);
    idle();
    repeat (4) step();
    check("sat_hold", stall_cnt_o, SATMAX);

    // Reset with both slots full and pending bits set: buffered writes must vanish.
    alloc_i = 1'b1; alloc_addr_i = 9;
    valid_0_i = 1'b1; addr_0_i = 10; data_0_i = 32'hA0A0;
    valid_1_i = 1'b1; addr_1_i = 11; data_1_i = 32'hB0B0;
    step();
    step();
    idle();
    rst_i = 1'b1;
    #1;
    check("midrst_ready_0", ready_0_o, 1);
    check("midrst_ready_1", ready_1_o, 1);
    check("midrst_we", we_o, 0);
    check("midrst_pend", pend_o, 0);
    check("midrst_stall", stall_cnt_o, 0);
    step();
    rst_i = 1'b0;
    issued.delete();
    repeat (5) step();
    check("midrst_no_write", issued.size(), 0);

    // Randomized traffic with varying density and occasional resets.
    for (int blk = 0; blk < 12; blk++) begin
      int dens;
      dens = $urandom_range(20, 95);
      for (int i = 0; i < 200; i++) begin
        valid_0_i    = ($urandom_range(99) < dens);
        addr_0_i     = AW'($urandom);
        data_0_i     = $urandom;
        valid_1_i    = ($urandom_range(99) < dens);
        addr_1_i     = AW'($urandom);
        data_1_i     = $urandom;
        alloc_i      = ($urandom_range(99) < 30);
        alloc_addr_i = AW'($urandom);
        rst_i        = ($urandom_range(299) == 0);
        step();
      end
      rst_i = 1'b0;
    end
    idle();
    repeat (5) step();
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
